// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Holds the FSM state encoding and the register-file geometry.
package rf_ctrl_pkg;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_ADDR_W   = 5;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_ARB   = 1'b1
   } rf_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: the pointer names the favoured requester
// when both are valid; a lone valid always wins.
module rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_ptr,
   output logic [1:0] o_grant
);
   assign o_grant[0] = i_valid[0] & (~i_valid[1] | ~i_ptr);
   assign o_grant[1] = i_valid[1] & (~i_valid[0] |  i_ptr);
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: optional post-reset clear of x1..x31,
// then round-robin arbitration of two write requesters with one-cycle latency.
module rf_write_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int INIT_CLEAR = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req0_valid_i,
   input  logic [RF_ADDR_W-1:0] req0_addr_i,
   input  logic [31:0]          req0_data_i,
   output logic                 req0_ready_o,
   input  logic                 req1_valid_i,
   input  logic [RF_ADDR_W-1:0] req1_addr_i,
   input  logic [31:0]          req1_data_i,
   output logic                 req1_ready_o,
   output logic [RF_ADDR_W-1:0] rf_write_addr_o,
   output logic [31:0]          rf_write_data_o,
   output logic                 rf_write_enable_o,
   output logic                 busy_o,
   output logic                 last_grant_o
);
   localparam rf_state_t            RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_ARB;
   localparam logic [RF_ADDR_W-1:0] LAST_REG    = RF_ADDR_W'(RF_NUM_REGS - 1);

   rf_state_t            r_state;
   rf_state_t            w_state_nxt;
   logic [RF_ADDR_W-1:0] r_clr_cnt;
   logic                 r_ptr;
   logic                 r_last_grant;
   logic [RF_ADDR_W-1:0] r_wr_addr;
   logic [31:0]          r_wr_data;
   logic                 r_wr_en;
   logic [1:0]           w_grant;
   logic                 w_arb;
   logic [1:0]           w_hs;

   rr_arbiter2 u_rr (
      .i_valid ({req1_valid_i, req0_valid_i}),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   // Readies are forced low while reset is held, even when reset lands in ARB.
   assign w_arb = (r_state == ST_ARB) & ~rst_i;
   assign w_hs  = w_arb ? w_grant : 2'b00;

   assign req0_ready_o      = w_hs[0];
   assign req1_ready_o      = w_hs[1];
   assign busy_o            = (r_state == ST_CLEAR);
   assign last_grant_o      = r_last_grant;
   assign rf_write_addr_o   = r_wr_addr;
   assign rf_write_data_o   = r_wr_data;
   assign rf_write_enable_o = r_wr_en;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == ST_CLEAR) && (r_clr_cnt == LAST_REG)) begin
         w_state_nxt = ST_ARB;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_clr_cnt    <= RF_ADDR_W'(1);
         r_ptr        <= 1'b0;
         r_last_grant <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_en      <= 1'b0;
      end else if (r_state == ST_CLEAR) begin
         r_wr_addr <= r_clr_cnt;
         r_wr_data <= '0;
         r_wr_en   <= 1'b1;
         r_clr_cnt <= r_clr_cnt + RF_ADDR_W'(1);
      end else if (w_hs[0]) begin
         // x0 is hardwired: the request is consumed but never written.
         r_wr_addr    <= req0_addr_i;
         r_wr_data    <= req0_data_i;
         r_wr_en      <= |req0_addr_i;
         r_ptr        <= 1'b1;
         r_last_grant <= 1'b0;
      end else if (w_hs[1]) begin
         r_wr_addr    <= req1_addr_i;
         r_wr_data    <= req1_data_i;
         r_wr_en      <= |req1_addr_i;
         r_ptr        <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_wr_en <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: one instance with clearing, one without,
// checked against a cycle model feeding an expected-write queue.
module tb_rf_write_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [4:0]  a0 = '0, a1 = '0;
   logic [31:0] d0 = '0, d1 = '0;

   logic        c_rdy0, c_rdy1, c_en, c_busy, c_last;
   logic [4:0]  c_addr;
   logic [31:0] c_data;
   logic        n_rdy0, n_rdy1, n_en, n_busy, n_last;
   logic [4:0]  n_addr;
   logic [31:0] n_data;

   logic        sel_clear = 1'b1;
   logic        o_rdy0, o_rdy1, o_en, o_busy, o_last;
   logic [4:0]  o_addr;
   logic [31:0] o_data;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        en;
   } wr_t;

   wr_t   exp_q[$];
   int    n_total = 0;
   int    n_bad   = 0;

   logic        m_clear, m_ptr, m_last;
   logic [4:0]  m_cnt;
   wr_t         m_out;

   logic [31:0] rf_mem [0:31];
   logic        rf_fill = 1'b0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.INIT_CLEAR(1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(c_rdy0),
      .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(c_rdy1),
      .rf_write_addr_o(c_addr), .rf_write_data_o(c_data), .rf_write_enable_o(c_en),
      .busy_o(c_busy), .last_grant_o(c_last)
   );

   rf_write_arbiter #(.INIT_CLEAR(0)) u_dut_nc (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(n_rdy0),
      .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(n_rdy1),
      .rf_write_addr_o(n_addr), .rf_write_data_o(n_data), .rf_write_enable_o(n_en),
      .busy_o(n_busy), .last_grant_o(n_last)
   );

   assign o_rdy0 = sel_clear ? c_rdy0 : n_rdy0;
   assign o_rdy1 = sel_clear ? c_rdy1 : n_rdy1;
   assign o_en   = sel_clear ? c_en   : n_en;
   assign o_busy = sel_clear ? c_busy : n_busy;
   assign o_last = sel_clear ? c_last : n_last;
   assign o_addr = sel_clear ? c_addr : n_addr;
   assign o_data = sel_clear ? c_data : n_data;

   // Register-file stand-in driven by the selected arbiter's write port.
   always @(posedge clk) begin
      if (rf_fill) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hDEADBEEF;
      end else if (o_en && (o_addr != 5'd0)) begin
         rf_mem[o_addr] <= o_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset(input logic init);
      sel_clear = init;
      rst       = 1'b1;
      m_clear   = init;
      m_cnt     = 5'd1;
      m_ptr     = 1'b0;
      m_last    = 1'b0;
      m_out     = '0;
      exp_q.delete();
      #2;
      chk("rst_en",   {31'd0, o_en},   32'd0);
      chk("rst_addr", {27'd0, o_addr}, 32'd0);
      chk("rst_data", o_data,          32'd0);
      chk("rst_busy", {31'd0, o_busy}, {31'd0, init});
      chk("rst_rdy0", {31'd0, o_rdy0}, 32'd0);
      chk("rst_rdy1", {31'd0, o_rdy1}, 32'd0);
      chk("rst_last", {31'd0, o_last}, 32'd0);
      rf_fill = 1'b1;
      @(posedge clk);
      #1 rf_fill = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cyc(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                      input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
      logic er0, er1;
      wr_t  nxt, got;
      v0 = iv0; a0 = ia0; d0 = id0;
      v1 = iv1; a1 = ia1; d1 = id1;
      #1;
      er0 = 1'b0;
      er1 = 1'b0;
      if (!m_clear) begin
         if (iv0 && iv1) begin
            er0 = ~m_ptr;
            er1 = m_ptr;
         end else begin
            er0 = iv0;
            er1 = iv1;
         end
      end
      chk("rdy0", {31'd0, o_rdy0}, {31'd0, er0});
      chk("rdy1", {31'd0, o_rdy1}, {31'd0, er1});
      chk("busy", {31'd0, o_busy}, {31'd0, m_clear});
      chk("last", {31'd0, o_last}, {31'd0, m_last});
      if (m_clear) begin
         nxt = '{addr: m_cnt, data: 32'd0, en: 1'b1};
         if (m_cnt == 5'd31) m_clear = 1'b0;
         m_cnt = m_cnt + 5'd1;
      end else if (er0) begin
         nxt    = '{addr: ia0, data: id0, en: (ia0 != 5'd0)};
         m_ptr  = 1'b1;
         m_last = 1'b0;
      end else if (er1) begin
         nxt    = '{addr: ia1, data: id1, en: (ia1 != 5'd0)};
         m_ptr  = 1'b0;
         m_last = 1'b1;
      end else begin
         nxt = '{addr: m_out.addr, data: m_out.data, en: 1'b0};
      end
      m_out = nxt;
      exp_q.push_back(nxt);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         chk("wr_addr", {27'd0, o_addr}, {27'd0, got.addr});
         chk("wr_data", o_data,          got.data);
         chk("wr_en",   {31'd0, o_en},   {31'd0, got.en});
      end
   endtask

   initial begin
      // Clearing instance; req0 addr 3 held across the whole clear sequence.
      v0 = 1'b1; a0 = 5'd3; d0 = 32'h0000_0033;
      v1 = 1'b1; a1 = 5'd9; d1 = 32'h0000_0099;
      do_reset(1'b1);
      for (int i = 0; i < 31; i++) cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
      for (int i = 1; i < 32; i++) chk("readback", rf_mem[i], 32'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd6, 32'h5555FFFF);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset pulse with the clear counter at 17, then a full restart.
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      do_reset(1'b1);
      for (int i = 0; i < 33; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Non-clearing instance: valids held high through reset, then random traffic.
      v0 = 1'b1; v1 = 1'b1;
      do_reset(1'b0);
      cyc(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
